// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : RV32I instruction fetch stage. Holds the PC, issues one word
//               request at a time to instruction memory, buffers a single
//               fetched instruction for decode and handles PC redirects by
//               flushing the buffer and discarding any stale response.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_instr,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_pc_plus4
);

    // FETCH: idle, WAIT: response will be kept, DROP: response will be discarded
    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_DROP  = 2'd2;

    localparam logic [XLEN-1:0] C_WORD       = XLEN'(4);
    localparam logic [XLEN-1:0] C_ALIGN_MASK = ~XLEN'(3);

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            id_valid_q, id_valid_d;
    logic [XLEN-1:0] id_instr_q, id_instr_d;
    logic [XLEN-1:0] id_pc_q, id_pc_d;
    logic [XLEN-1:0] id_pc_plus4_q, id_pc_plus4_d;

    logic w_buf_free;
    logic w_req_fire;
    logic w_load;

    assign w_buf_free = !id_valid_q || id_ready;
    assign w_req_fire = imem_req_valid && imem_req_ready;
    // A kept response is only written to the buffer when no redirect kills it
    assign w_load     = (state_q == S_WAIT) && imem_rsp_valid && !redirect_valid;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: track the single outstanding request and whether it is stale
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (w_req_fire) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    state_d = S_FETCH;
                end else if (redirect_valid) begin
                    state_d = S_DROP;
                end
            end
            S_DROP: begin
                if (imem_rsp_valid) begin
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Outputs: request only when idle, buffer can take the result, and no redirect
    always_comb begin
        imem_req_valid = (state_q == S_FETCH) && w_buf_free && !redirect_valid;
        imem_addr      = pc_q;
    end

    // Datapath next values; redirect overrides PC advance and flushes the buffer
    always_comb begin
        pc_d          = pc_q;
        req_pc_d      = req_pc_q;
        id_valid_d    = id_valid_q;
        id_instr_d    = id_instr_q;
        id_pc_d       = id_pc_q;
        id_pc_plus4_d = id_pc_plus4_q;

        if (w_req_fire) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + C_WORD;
        end

        if (w_load) begin
            id_instr_d    = imem_rsp_data;
            id_pc_d       = req_pc_q;
            id_pc_plus4_d = req_pc_q + C_WORD;
            id_valid_d    = 1'b1;
        end else if (id_valid_q && id_ready) begin
            id_valid_d = 1'b0;
        end

        if (redirect_valid) begin
            pc_d       = redirect_pc & C_ALIGN_MASK;
            id_valid_d = 1'b0;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            req_pc_q      <= '0;
            id_valid_q    <= 1'b0;
            id_instr_q    <= '0;
            id_pc_q       <= '0;
            id_pc_plus4_q <= '0;
        end else begin
            pc_q          <= pc_d;
            req_pc_q      <= req_pc_d;
            id_valid_q    <= id_valid_d;
            id_instr_q    <= id_instr_d;
            id_pc_q       <= id_pc_d;
            id_pc_plus4_q <= id_pc_plus4_d;
        end
    end

    assign id_valid    = id_valid_q;
    assign id_instr    = id_instr_q;
    assign id_pc       = id_pc_q;
    assign id_pc_plus4 = id_pc_plus4_q;

    // imem must never respond while no request is outstanding
    a_no_rsp_in_fetch: assert property (@(posedge clk) disable iff (!rst_n)
        !((state_q == S_FETCH) && imem_rsp_valid));

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Self-checking bench for fetch_stage. A transaction-level model
//               (next PC, one outstanding request record, one-entry buffer)
//               predicts outputs each cycle; directed sequences pin literals.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    localparam logic [31:0] RST_PC  = 32'h0000_0100;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;

    logic        imem_req_valid, id_valid;
    logic [31:0] imem_addr, id_instr, id_pc, id_pc_plus4;
    logic        wr_imem_req_valid, wr_id_valid;
    logic [31:0] wr_imem_addr, wr_id_instr, wr_id_pc, wr_id_pc_plus4;

    always #5 clk = ~clk;

    fetch_stage #(.XLEN(32), .RESET_PC(RST_PC)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .id_valid(id_valid), .id_ready(id_ready),
        .id_instr(id_instr), .id_pc(id_pc), .id_pc_plus4(id_pc_plus4)
    );

    // Second instance sharing all inputs: same handshakes, PC starts at the top
    fetch_stage #(.XLEN(32), .RESET_PC(WRAP_PC)) u_wrap (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(wr_imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_addr(wr_imem_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .id_valid(wr_id_valid), .id_ready(id_ready),
        .id_instr(wr_id_instr), .id_pc(wr_id_pc), .id_pc_plus4(wr_id_pc_plus4)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    bit          m_out, m_keep, m_buf_v;
    logic [31:0] m_pc, m_out_addr, m_buf_instr, m_buf_pc;
    // imem environment state
    bit          e_pend;
    int          e_lat;
    logic [31:0] e_addr;
    // Stimulus controls
    bit          rnd;
    bit          d_ready, d_id_ready, d_redir;
    logic [31:0] d_rpc;
    int          lat_fix;
    // Outputs sampled mid-cycle by step()
    bit          s_req_valid, s_id_valid, s_w_req_valid, s_w_id_valid;
    logic [31:0] s_addr, s_id_instr, s_id_pc, s_id_pc4;
    logic [31:0] s_w_addr, s_w_id_instr, s_w_id_pc, s_w_id_pc4;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 32'h0050_0093;
            32'h0000_0104: return 32'h0010_0113;
            default:       return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
        endcase
    endfunction

    task automatic model_reset();
        m_pc    = RST_PC;
        m_out   = 1'b0;
        m_keep  = 1'b0;
        m_buf_v = 1'b0;
        e_pend  = 1'b0;
        e_lat   = 0;
    endtask

    // One clock cycle: drive inputs, compare against the model, advance model
    task automatic step();
        bit          m_req, fire_m, consume, deliver, e_fire;
        logic [31:0] e_fire_addr;
        @(negedge clk);
        if (rnd) begin
            imem_req_ready = ($urandom_range(0, 3) != 0);
            id_ready       = ($urandom_range(0, 2) != 0);
            redirect_valid = ($urandom_range(0, 9) == 0);
            redirect_pc    = $urandom;
        end else begin
            imem_req_ready = d_ready;
            id_ready       = d_id_ready;
            redirect_valid = d_redir;
            redirect_pc    = d_rpc;
        end
        imem_rsp_valid = e_pend && (e_lat == 0);
        imem_rsp_data  = imem_rsp_valid ? mem_word(e_addr) : $urandom;
        #4;
        m_req = !m_out && (!m_buf_v || id_ready) && !redirect_valid;
        chk1("imem_req_valid", imem_req_valid, m_req);
        chk32("imem_addr", imem_addr, m_pc);
        chk1("id_valid", id_valid, m_buf_v);
        if (m_buf_v) begin
            chk32("id_instr", id_instr, m_buf_instr);
            chk32("id_pc", id_pc, m_buf_pc);
            chk32("id_pc_plus4", id_pc_plus4, m_buf_pc + 32'd4);
        end
        s_req_valid   = imem_req_valid;   s_addr       = imem_addr;
        s_id_valid    = id_valid;         s_id_instr   = id_instr;
        s_id_pc       = id_pc;            s_id_pc4     = id_pc_plus4;
        s_w_req_valid = wr_imem_req_valid; s_w_addr    = wr_imem_addr;
        s_w_id_valid  = wr_id_valid;      s_w_id_instr = wr_id_instr;
        s_w_id_pc     = wr_id_pc;         s_w_id_pc4   = wr_id_pc_plus4;
        e_fire      = imem_req_valid && imem_req_ready;
        e_fire_addr = imem_addr;
        @(posedge clk);
        fire_m  = m_req && imem_req_ready;
        consume = m_buf_v && id_ready;
        deliver = 1'b0;
        if (imem_rsp_valid && m_out) begin
            deliver = m_keep && !redirect_valid;
            m_out   = 1'b0;
        end
        if (redirect_valid) begin
            m_buf_v = 1'b0;
        end else if (deliver) begin
            m_buf_v     = 1'b1;
            m_buf_instr = imem_rsp_data;
            m_buf_pc    = m_out_addr;
        end else if (consume) begin
            m_buf_v = 1'b0;
        end
        if (redirect_valid) begin
            m_pc = {redirect_pc[31:2], 2'b00};
            if (m_out) m_keep = 1'b0;
        end else if (fire_m) begin
            m_out      = 1'b1;
            m_keep     = 1'b1;
            m_out_addr = m_pc;
            m_pc       = m_pc + 32'd4;
        end
        if (imem_rsp_valid) e_pend = 1'b0;
        else if (e_pend) e_lat--;
        if (e_fire) begin
            e_pend = 1'b1;
            e_addr = e_fire_addr;
            e_lat  = rnd ? int'($urandom_range(0, 2)) : lat_fix;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0;
        d_ready = 1'b0; d_id_ready = 1'b0; d_redir = 1'b0; d_rpc = '0; lat_fix = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        rnd = 1'b1;
        repeat (400) step();

        // Asynchronous reset in the middle of random traffic
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk1("rst id_valid", id_valid, 1'b0);
        chk32("rst id_instr", id_instr, 32'h0);
        chk32("rst id_pc", id_pc, 32'h0);
        chk32("rst id_pc_plus4", id_pc_plus4, 32'h0);
        chk32("rst imem_addr", imem_addr, 32'h0000_0100);
        chk32("rst wrap imem_addr", wr_imem_addr, 32'hFFFF_FFFC);
        imem_rsp_valid = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk1("rst hold id_valid", id_valid, 1'b0);
        d_ready = 1'b1; d_id_ready = 1'b1; d_redir = 1'b0; d_rpc = '0; lat_fix = 0;
        rnd = 1'b0;
        #1 rst_n = 1'b1;

        // Stream with single-cycle imem
        step();
        chk1("c0 req_valid", s_req_valid, 1'b1);
        chk32("c0 addr", s_addr, 32'h0000_0100);
        chk1("c0 wrap req_valid", s_w_req_valid, 1'b1);
        chk32("c0 wrap addr", s_w_addr, 32'hFFFF_FFFC);
        step();
        chk1("c1 req_valid", s_req_valid, 1'b0);
        step();
        chk1("c2 id_valid", s_id_valid, 1'b1);
        chk32("c2 id_instr", s_id_instr, 32'h0050_0093);
        chk32("c2 id_pc", s_id_pc, 32'h0000_0100);
        chk32("c2 id_pc_plus4", s_id_pc4, 32'h0000_0104);
        chk32("c2 addr", s_addr, 32'h0000_0104);
        chk1("c2 wrap id_valid", s_w_id_valid, 1'b1);
        chk32("c2 wrap id_instr", s_w_id_instr, 32'h0050_0093);
        chk32("c2 wrap id_pc", s_w_id_pc, 32'hFFFF_FFFC);
        chk32("c2 wrap id_pc_plus4", s_w_id_pc4, 32'h0000_0000);
        chk32("c2 wrap addr", s_w_addr, 32'h0000_0000);
        step();
        chk1("c3 id_valid", s_id_valid, 1'b0);

        // Backpressure for 5 cycles
        d_id_ready = 1'b0;
        step();
        chk1("c4 id_valid", s_id_valid, 1'b1);
        chk32("c4 id_instr", s_id_instr, 32'h0010_0113);
        chk32("c4 id_pc", s_id_pc, 32'h0000_0104);
        chk32("c4 id_pc_plus4", s_id_pc4, 32'h0000_0108);
        chk1("c4 req_valid", s_req_valid, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk32("bp id_pc", s_id_pc, 32'h0000_0104);
            chk32("bp id_instr", s_id_instr, 32'h0010_0113);
            chk1("bp req_valid", s_req_valid, 1'b0);
        end
        d_id_ready = 1'b1; lat_fix = 1;
        step();
        chk1("c9 req_valid", s_req_valid, 1'b1);
        chk32("c9 addr", s_addr, 32'h0000_0108);

        // Redirect while the request for 0x108 is outstanding
        d_redir = 1'b1; d_rpc = 32'h0000_0203;
        step();
        chk1("c10 id_valid", s_id_valid, 1'b0);
        d_redir = 1'b0; lat_fix = 0;
        step();
        chk1("c11 id_valid", s_id_valid, 1'b0);
        chk1("c11 req_valid", s_req_valid, 1'b0);
        chk32("c11 addr", s_addr, 32'h0000_0200);
        step();
        chk1("c12 id_valid", s_id_valid, 1'b0);
        chk1("c12 req_valid", s_req_valid, 1'b1);
        chk32("c12 addr", s_addr, 32'h0000_0200);
        step();
        step();
        chk1("c14 id_valid", s_id_valid, 1'b1);
        chk32("c14 id_pc", s_id_pc, 32'h0000_0200);
        chk32("c14 id_pc_plus4", s_id_pc4, 32'h0000_0204);

        // Redirect coincident with the response
        d_redir = 1'b1; d_rpc = 32'h0000_0300; d_id_ready = 1'b0;
        step();
        d_redir = 1'b0; d_id_ready = 1'b1;
        step();
        chk1("c16 id_valid", s_id_valid, 1'b0);
        chk1("c16 req_valid", s_req_valid, 1'b1);
        chk32("c16 addr", s_addr, 32'h0000_0300);
        step();

        // Redirect with a full buffer that decode is not taking
        d_id_ready = 1'b0; d_redir = 1'b1; d_rpc = 32'h0000_0400;
        step();
        chk1("c18 id_valid", s_id_valid, 1'b1);
        chk32("c18 id_pc", s_id_pc, 32'h0000_0300);
        d_redir = 1'b0; d_id_ready = 1'b1;
        step();
        chk1("c19 id_valid", s_id_valid, 1'b0);
        chk1("c19 req_valid", s_req_valid, 1'b1);
        chk32("c19 addr", s_addr, 32'h0000_0400);

        rnd = 1'b1;
        repeat (400) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage of the RV32I pipeline. It sits directly upstream of the decode/control stage.
- Holds the PC and issues word requests to instruction memory over a valid/ready request channel with a variable-latency response.
- Hands {instruction, PC, PC+4} to decode over a valid/ready channel.
- Accepts PC redirects from branch/JAL/JALR resolution, flushing in-flight and buffered instructions.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (bits [1:0] must be 0)
XLEN, 32, address/instruction width

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  reset, asynchronous assert, active-low
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  imem accepts request this cycle
imem_addr  out  XLEN  fetch word address, [1:0] always 0
imem_rsp_valid  in  1  response data valid (one pulse per accepted request, no backpressure)
imem_rsp_data  in  XLEN  fetched instruction
redirect_valid  in  1  redirect PC this cycle (branch taken / JAL / JALR)
redirect_pc  in  XLEN  redirect target; bits [1:0] ignored, forced 0
id_valid  out  1  instruction buffer holds valid instruction for decode
id_ready  in  1  decode consumes buffer this cycle
id_instr  out  XLEN  instruction; opcode [6:0], funct3 [14:12], funct7 [31:25] feed decode control
id_pc  out  XLEN  address of id_instr
id_pc_plus4  out  XLEN  id_pc + 4, used for JAL/JALR link writeback

Behaviour:
- Reset (rst_n low, asynchronous):
  - pc = RESET_PC; state = FETCH; id_valid = 0.
  - id_instr, id_pc and id_pc_plus4 = 0.
  - Outputs stay at these values until the first clk edge after rst_n rises.
- Reset mid-operation: discard any outstanding request. imem must also be reset by the same rst_n. No response is expected after reset.
- States:
  - FETCH: no request outstanding.
  - WAIT: one request outstanding; its response is kept.
  - DROP: one request outstanding; its response is discarded.
- At most one outstanding request.
- buf_free = !id_valid || id_ready.
- imem_req_valid = (state==FETCH) && buf_free && !redirect_valid.
- imem_addr = pc (combinational from the register).
- FETCH:
  - On imem_req_valid && imem_req_ready: req_pc <= pc; pc <= pc+4; go to WAIT.
  - If the request is not accepted, pc is unchanged and the request stays stable.
  - Exception: redirect_valid may withdraw a pending request.
- WAIT, on imem_rsp_valid:
  - id_instr <= imem_rsp_data; id_pc <= req_pc; id_pc_plus4 <= req_pc+4.
  - id_valid <= 1; go to FETCH.
  - The buffer is guaranteed free here: it drained when the request issued, and nothing refills it while in WAIT.
- DROP: on imem_rsp_valid, discard the data; id_valid is not set; go to FETCH.
- Decode handshake:
  - id_valid && id_ready with no new load clears id_valid next cycle.
  - id_* are stable while id_valid && !id_ready.
- Redirect has the highest priority and is evaluated every cycle:
  - pc <= {redirect_pc[31:2],2'b00}; id_valid <= 0 (flush), regardless of id_ready.
  - FETCH: no request issues that cycle; stay in FETCH.
  - WAIT without rsp the same cycle: go to DROP.
  - WAIT with rsp the same cycle: discard the response; go to FETCH.
  - DROP: stay in DROP, or go to FETCH if rsp arrives the same cycle.
  - Back-to-back redirects: the last one wins.
- Latency:
  - Redirect in cycle N: the request for the target is visible at N+1 if no request is outstanding; otherwise in the cycle after the stale response.
  - Response in cycle M: id_valid is high at M+1.
  - The next request may issue at M+1 when buf_free.
- Throughput: max one instruction per 2 cycles with single-cycle imem, by design.
- Arithmetic: PC increments modulo 2^32, so 32'hFFFF_FFFC + 4 = 0. The same rule applies to id_pc_plus4.
- imem_rsp_valid in FETCH (protocol violation): ignored. An assertion flags it in simulation.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with RESET_PC=32'h0000_0100 -> id_valid=0 immediately. After release, first imem_addr=32'h100, then 32'h104, 32'h108.
- Stream: imem ready=1, rsp 1 cycle after accept with data 32'h00500093, 32'h00100113 -> id_instr/id_pc pairs (32'h00500093, 32'h100) and (32'h00100113, 32'h104). id_pc_plus4=32'h104 and 32'h108.
- Backpressure: id_ready=0 for 5 cycles with id_valid=1 -> id_instr/id_pc held constant; imem_req_valid=0. After id_ready=1, next request is issued in the same cycle.
- Redirect in WAIT: redirect_pc=32'h0000_0203 while a request for 32'h108 is outstanding -> its response is dropped (id_valid stays 0). Next imem_addr=32'h200, then id_pc=32'h200.
- Redirect coincident with response and with a full buffer -> id_valid=0 next cycle, response discarded. Next request is issued to the target the following cycle.
- Wrap: RESET_PC=32'hFFFF_FFFC -> first id_pc=32'hFFFF_FFFC, id_pc_plus4=0; next imem_addr=0.
